wlast_burst_tracker: RTL and testbench

- Parametrised write-last generator for the interconnect write data path.
- Captures the burst length of every accepted AW handshake into a small length FIFO and counts W beats against the head entry.
- Drives the slave-side WLAST exactly on the final beat of each burst.
- Supports multiple outstanding bursts, a pass-through/OR mode for masters that supply their own WLAST, and a checking mode that flags master WLAST mismatches.

---
 rtl/wlast_burst_tracker.sv | 115 +++++++++++
 tb/tb_wlast_burst_tracker.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wlast_burst_tracker.sv
// Write-last generator: queues AW burst lengths and counts W beats against the head
// entry, driving WLAST to the slave on the final beat (with optional OR / check modes).
module wlast_burst_tracker #(
  parameter int LEN_W = 8,
  parameter int DEPTH = 4,
  parameter int MODE  = 0
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             Enable,
  input  logic             aw_valid,
  input  logic             aw_ready,
  input  logic [LEN_W-1:0] aw_len,
  input  logic             w_valid,
  input  logic             w_ready,
  input  logic             m_wlast,
  output logic             s_wlast,
  output logic             len_full,
  output logic             len_empty,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             overflow_err,
  output logic             underflow_err,
  output logic             mismatch_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [LEN_W-1:0] mem_q [DEPTH];
  logic [LEN_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             mismatch_q, mismatch_d;

  logic             aw_hs, w_hs, push, pop, gen_last;
  logic [LEN_W-1:0] head_len;

  assign len_full  = (count_q == FULL_CNT);
  assign len_empty = (count_q == '0);
  assign head_len  = mem_q[rd_ptr_q];
  assign gen_last  = !len_empty && (beat_cnt_q == head_len);

  // Enable gates both handshakes, so every state update below freezes with it.
  assign aw_hs = aw_valid & aw_ready & Enable;
  assign w_hs  = w_valid & w_ready & Enable;
  assign pop   = w_hs & gen_last;
  // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted.
  assign push  = aw_hs & (!len_full | pop);

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    beat_cnt_d  = beat_cnt_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mismatch_d  = mismatch_q;

    if (push) begin
      mem_d[wr_ptr_q] = aw_len;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (w_hs && !len_empty) begin
      beat_cnt_d = gen_last ? '0 : beat_cnt_q + 1'b1;
    end

    if (aw_hs && len_full && !pop) overflow_d = 1'b1;
    if (w_hs && len_empty) underflow_d = 1'b1;
    if ((MODE == 2) && w_hs && !len_empty && (m_wlast != gen_last)) mismatch_d = 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      beat_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      beat_cnt_q  <= beat_cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign s_wlast       = (MODE == 1) ? (gen_last | m_wlast) : gen_last;
  assign beat_cnt      = beat_cnt_q;
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;
  assign mismatch_err  = mismatch_q;

endmodule

// File: tb/tb_wlast_burst_tracker.sv
// Bench for wlast_burst_tracker: three instances (MODE 0/1/2) share one stimulus stream
// and are compared each cycle against a queue-based model of the burst bookkeeping.
module tb_wlast_burst_tracker;

  localparam int LEN_W = 8;
  localparam int DEPTH = 4;

  // clock / reset
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  logic             Enable = 1'b1;
  logic             aw_valid = 1'b0, aw_ready = 1'b0;
  logic [LEN_W-1:0] aw_len = '0;
  logic             w_valid = 1'b0, w_ready = 1'b0, m_wlast = 1'b0;

  logic [2:0]       s_wlast, len_full, len_empty, ovf, unf, mis;
  logic [LEN_W-1:0] beat_cnt [3];

  wlast_burst_tracker #(.LEN_W(LEN_W), .DEPTH(DEPTH), .MODE(0)) u_m0 (
    .ACLK(ACLK), .ARESET(ARESET), .Enable(Enable),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .m_wlast(m_wlast),
    .s_wlast(s_wlast[0]), .len_full(len_full[0]), .len_empty(len_empty[0]),
    .beat_cnt(beat_cnt[0]), .overflow_err(ovf[0]), .underflow_err(unf[0]),
    .mismatch_err(mis[0]));

  wlast_burst_tracker #(.LEN_W(LEN_W), .DEPTH(DEPTH), .MODE(1)) u_m1 (
    .ACLK(ACLK), .ARESET(ARESET), .Enable(Enable),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .m_wlast(m_wlast),
    .s_wlast(s_wlast[1]), .len_full(len_full[1]), .len_empty(len_empty[1]),
    .beat_cnt(beat_cnt[1]), .overflow_err(ovf[1]), .underflow_err(unf[1]),
    .mismatch_err(mis[1]));

  wlast_burst_tracker #(.LEN_W(LEN_W), .DEPTH(DEPTH), .MODE(2)) u_m2 (
    .ACLK(ACLK), .ARESET(ARESET), .Enable(Enable),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .m_wlast(m_wlast),
    .s_wlast(s_wlast[2]), .len_full(len_full[2]), .len_empty(len_empty[2]),
    .beat_cnt(beat_cnt[2]), .overflow_err(ovf[2]), .underflow_err(unf[2]),
    .mismatch_err(mis[2]));

  // scoreboard: queued burst lengths (beats-1) and beats taken from the head burst
  int m_q[$];
  int m_beats;
  bit m_ovf, m_unf, m_mis;

  int checks = 0;
  int failures = 0;

  // per-phase log of beat numbers on which WLAST was seen (MODE 0 and MODE 1)
  int beat_idx;
  int last0_q[$];
  int last1_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_list(input string name, input int which, input int n, input int e[8]);
    int sz;
    sz = (which == 0) ? last0_q.size() : last1_q.size();
    check({name, "_count"}, sz, n);
    for (int i = 0; i < n && i < sz; i++)
      check($sformatf("%s_beat%0d", name, i), (which == 0) ? last0_q[i] : last1_q[i], e[i]);
  endtask

  task automatic model_step();
    bit aw, w, emp, gen;
    if (ARESET) begin
      m_q.delete();
      m_beats = 0;
      m_ovf = 0; m_unf = 0; m_mis = 0;
      return;
    end
    aw  = aw_valid && aw_ready && Enable;
    w   = w_valid && w_ready && Enable;
    emp = (m_q.size() == 0);
    gen = !emp && (m_beats == m_q[0]);
    if (w && emp) m_unf = 1;
    if (w && !emp) begin
      if (m_wlast != gen) m_mis = 1;
      if (gen) begin
        void'(m_q.pop_front());
        m_beats = 0;
      end else begin
        m_beats++;
      end
    end
    if (aw) begin
      if (m_q.size() < DEPTH) m_q.push_back(int'(aw_len));
      else m_ovf = 1;
    end
  endtask

  task automatic compare_outputs();
    bit emp, full, gen, exp_last;
    emp  = (m_q.size() == 0);
    full = (m_q.size() == DEPTH);
    gen  = !emp && (m_beats == m_q[0]);
    for (int k = 0; k < 3; k++) begin
      exp_last = (k == 1) ? (gen | m_wlast) : gen;
      check($sformatf("s_wlast_m%0d", k), s_wlast[k], exp_last);
      check($sformatf("len_full_m%0d", k), len_full[k], full);
      check($sformatf("len_empty_m%0d", k), len_empty[k], emp);
      check($sformatf("beat_cnt_m%0d", k), beat_cnt[k], m_beats);
      check($sformatf("overflow_m%0d", k), ovf[k], m_ovf);
      check($sformatf("underflow_m%0d", k), unf[k], m_unf);
      check($sformatf("mismatch_m%0d", k), mis[k], (k == 2) ? m_mis : 1'b0);
    end
    if (!ARESET && w_valid && w_ready && Enable) begin
      beat_idx++;
      if (s_wlast[0]) last0_q.push_back(beat_idx);
      if (s_wlast[1]) last1_q.push_back(beat_idx);
    end
  endtask

  // one clock: compare on the falling edge, advance the model on the rising edge
  task automatic cycle();
    @(negedge ACLK);
    compare_outputs();
    @(posedge ACLK);
    model_step();
    #1;
  endtask

  // driver tasks
  task automatic clear_log();
    beat_idx = 0;
    last0_q.delete();
    last1_q.delete();
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    cycle();
    ARESET = 1'b0;
  endtask

  task automatic aw(input int len);
    aw_valid = 1'b1; aw_ready = 1'b1; aw_len = LEN_W'(len);
    cycle();
    aw_valid = 1'b0; aw_ready = 1'b0;
  endtask

  task automatic wbeat(input bit mw);
    w_valid = 1'b1; w_ready = 1'b1; m_wlast = mw;
    cycle();
    w_valid = 1'b0; w_ready = 1'b0; m_wlast = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge ACLK);
    model_step();
    #1;
    ARESET = 1'b0;

    // reset state
    check("rst_s_wlast", s_wlast[0], 0);
    check("rst_len_empty", len_empty[0], 1);
    check("rst_len_full", len_full[0], 0);
    check("rst_beat_cnt", beat_cnt[0], 0);

    // single 4-beat burst
    clear_log();
    aw(3);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b4_cnt%0d", i), beat_cnt[0], i);
      wbeat(1'b0);
    end
    check("b4_cnt_end", beat_cnt[0], 0);
    check("b4_empty_end", len_empty[0], 1);
    check_list("b4_last", 0, 1, '{4, 0, 0, 0, 0, 0, 0, 0});

    // fill with 0,1,15,255 then stream 275 beats
    clear_log();
    aw(0); aw(1); aw(15); aw(255);
    check("fill_full", len_full[0], 1);
    w_valid = 1'b1; w_ready = 1'b1;
    for (int i = 0; i < 275; i++) cycle();
    w_valid = 1'b0; w_ready = 1'b0;
    check("stream_empty", len_empty[0], 1);
    check("stream_ovf", ovf[0], 0);
    check("stream_unf", unf[0], 0);
    check_list("stream_last", 0, 4, '{1, 3, 19, 275, 0, 0, 0, 0});

    // push while full with a simultaneous final beat, then a real overflow
    clear_log();
    aw(1); aw(1); aw(1); aw(1);
    wbeat(1'b0);
    aw_valid = 1'b1; aw_ready = 1'b1; aw_len = 8'd2;
    w_valid = 1'b1; w_ready = 1'b1;
    cycle();
    aw_valid = 1'b0; aw_ready = 1'b0; w_valid = 1'b0; w_ready = 1'b0;
    check("pushpop_full", len_full[0], 1);
    check("pushpop_ovf", ovf[0], 0);
    aw(5);
    check("overflow_set", ovf[0], 1);
    for (int i = 0; i < 9; i++) wbeat(1'b0);
    check("drain_empty", len_empty[0], 1);
    check_list("drain_last", 0, 5, '{2, 4, 6, 8, 11, 0, 0, 0});

    // underflow, then a 2-beat burst
    do_reset();
    wbeat(1'b1);
    check("unf_set", unf[0], 1);
    check("unf_cnt", beat_cnt[0], 0);
    clear_log();
    aw(1);
    wbeat(1'b0); wbeat(1'b0);
    check_list("unf_b2_last", 0, 1, '{2, 0, 0, 0, 0, 0, 0, 0});

    // early master WLAST on beat 2 of a 3-beat burst
    do_reset();
    clear_log();
    aw(2);
    wbeat(1'b0); wbeat(1'b1);
    check("mis_m2_set", mis[2], 1);
    wbeat(1'b0);
    check("mis_m1_clear", mis[1], 0);
    check_list("mis_m0_last", 0, 1, '{3, 0, 0, 0, 0, 0, 0, 0});
    check_list("mis_m1_last", 1, 2, '{2, 3, 0, 0, 0, 0, 0, 0});

    // reset mid-burst, then Enable low during a W handshake
    do_reset();
    aw(7);
    wbeat(1'b0); wbeat(1'b0); wbeat(1'b0);
    check("mid_cnt", beat_cnt[0], 3);
    do_reset();
    check("mid_rst_cnt", beat_cnt[0], 0);
    check("mid_rst_empty", len_empty[0], 1);
    check("mid_rst_flags", {ovf, unf, mis}, 0);
    aw(7);
    Enable = 1'b0;
    aw_valid = 1'b1; aw_ready = 1'b1; w_valid = 1'b1; w_ready = 1'b1;
    cycle();
    aw_valid = 1'b0; aw_ready = 1'b0; w_valid = 1'b0; w_ready = 1'b0;
    Enable = 1'b1;
    check("en_low_cnt", beat_cnt[0], 0);
    wbeat(1'b0);
    check("en_high_cnt", beat_cnt[0], 1);

    // random: legal traffic first, then unconstrained with resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit legal;
      legal    = (i < 1800);
      ARESET   = (!legal && $urandom_range(0, 99) == 0);
      Enable   = ($urandom_range(0, 9) != 0);
      aw_valid = $urandom_range(0, 1);
      aw_ready = $urandom_range(0, 1) && (!legal || m_q.size() < DEPTH);
      aw_len   = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom_range(0, 255))
                                             : LEN_W'($urandom_range(0, 5));
      w_valid  = ($urandom_range(0, 3) != 0) && (!legal || m_q.size() > 0);
      w_ready  = ($urandom_range(0, 3) != 0);
      m_wlast  = ($urandom_range(0, 3) == 0);
      cycle();
    end
    ARESET = 1'b0;
    aw_valid = 1'b0; aw_ready = 1'b0; w_valid = 1'b0; w_ready = 1'b0; m_wlast = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
